// File: rtl/ddr_traffic_gen_chk.sv
// ddr_traffic_gen_chk: DDR4 UI traffic generator and read-data checker.
// Issues COUNT write and/or read commands starting at BASE_ADDR, stepping by
// ADDR_STEP. Write data is a per-lane pattern (optionally XOR-ed with the
// command index and lane number). Returning read data is compared in order
// against the same pattern, and errors are counted.
// Ports:
//   c0_ddr4_ui_clk, c0_ddr4_ui_aresetn   : clock, async active-low reset
//   reg_we/reg_addr/reg_wdata/reg_rdata  : register access (rdata combinational)
//   c0_init_calib_complete               : memory calibration done
//   app_*                                : DDR4 MIG user-interface command/data
module ddr_traffic_gen_chk #(
    parameter int APP_DATA_W      = 512,
    parameter int APP_ADDR_W      = 31,
    parameter int ADDR_STEP       = 8,
    parameter int MAX_OUTSTANDING = 16,
    parameter int REG_ADDR_W      = 12
) (
    input  logic                    c0_ddr4_ui_clk,
    input  logic                    c0_ddr4_ui_aresetn,
    input  logic                    reg_we,
    input  logic [REG_ADDR_W-1:0]   reg_addr,
    input  logic [31:0]             reg_wdata,
    output logic [31:0]             reg_rdata,
    input  logic                    c0_init_calib_complete,
    output logic                    app_en,
    output logic [2:0]              app_cmd,
    output logic [APP_ADDR_W-1:0]   app_addr,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    output logic [APP_DATA_W-1:0]   app_wdf_data,
    output logic [APP_DATA_W/8-1:0] app_wdf_mask,
    input  logic                    app_rdy,
    input  logic                    app_wdf_rdy,
    input  logic                    app_rd_data_valid,
    input  logic [APP_DATA_W-1:0]   app_rd_data
);

    localparam int NW = APP_DATA_W / 32;
    localparam int OW = 7;

    localparam logic [REG_ADDR_W-1:0] A_CTRL   = REG_ADDR_W'(32'h04);
    localparam logic [REG_ADDR_W-1:0] A_STATUS = REG_ADDR_W'(32'h08);
    localparam logic [REG_ADDR_W-1:0] A_COUNT  = REG_ADDR_W'(32'h0C);
    localparam logic [REG_ADDR_W-1:0] A_BASE   = REG_ADDR_W'(32'h10);
    localparam logic [REG_ADDR_W-1:0] A_PAT    = REG_ADDR_W'(32'h14);
    localparam logic [REG_ADDR_W-1:0] A_ERR    = REG_ADDR_W'(32'h18);
    localparam logic [REG_ADDR_W-1:0] A_FIRST  = REG_ADDR_W'(32'h1C);
    localparam logic [REG_ADDR_W-1:0] A_BUSY   = REG_ADDR_W'(32'h20);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3
    } state_t;

    // Builds the full data word for one command index: every 32-bit lane is
    // PATTERN, optionally XOR-ed with {index[23:0], 4'h0, lane[3:0]}.
    function automatic logic [APP_DATA_W-1:0] gen_data(input logic [31:0] pat,
                                                       input logic [23:0] idx,
                                                       input logic        use_xor);
        logic [APP_DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NW; i++) begin
            v[i*32 +: 32] = use_xor ? (pat ^ {idx, 4'h0, 4'(i)}) : pat;
        end
        return v;
    endfunction

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_mode;
    logic                    r_xor;
    logic [31:0]             r_count;
    logic [APP_ADDR_W-1:0]   r_base;
    logic [31:0]             r_pattern;
    logic [31:0]             r_err_cnt;
    logic [31:0]             r_first_err_idx;
    logic [31:0]             r_busy_cycles;
    logic                    r_done;
    logic                    r_err_seen;
    logic                    r_start_rej;
    logic [31:0]             r_n;
    logic [APP_ADDR_W-1:0]   r_addr;
    logic [31:0]             r_m;
    logic [OW-1:0]           r_outstanding;
    logic                    r_rd_vld;
    logic [APP_DATA_W-1:0]   r_rd_data;

    logic                    w_ctrl_we;
    logic                    w_start;
    logic                    w_stop;
    logic                    w_start_ok;
    logic                    w_start_rej;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_rd_acc;
    logic                    w_rd_ret;
    logic                    w_mis;
    logic [APP_DATA_W-1:0]   w_exp;

    assign w_ctrl_we   = reg_we && (reg_addr == A_CTRL);
    assign w_start     = w_ctrl_we && reg_wdata[0];
    assign w_stop      = w_ctrl_we && reg_wdata[4];
    assign w_start_ok  = w_start && (r_state == ST_IDLE) && (r_count != 32'd0) &&
                         c0_init_calib_complete && (reg_wdata[2:1] != 2'd3);
    assign w_start_rej = w_start && (r_state == ST_IDLE) && !w_start_ok;
    assign w_last      = (r_n == (r_count - 32'd1));
    assign w_rd_acc    = w_accept && (r_state == ST_RD);
    // A return with nothing outstanding is ignored so the counter never wraps.
    assign w_rd_ret    = app_rd_data_valid && (r_outstanding != {OW{1'b0}});

    assign app_addr     = r_addr;
    assign app_wdf_end  = 1'b1;
    assign app_wdf_mask = '0;
    assign app_wdf_data = (r_state == ST_WR) ? gen_data(r_pattern, r_n[23:0], r_xor) : '0;

    assign w_exp = gen_data(r_pattern, r_m[23:0], r_xor);
    assign w_mis = r_rd_vld && (r_rd_data != w_exp);

    // State register.
    always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_ui_aresetn) begin
        if (!c0_ddr4_ui_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and UI handshake outputs.
    always_comb begin
        w_state_nxt  = r_state;
        app_en       = 1'b0;
        app_cmd      = 3'd0;
        app_wdf_wren = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = (reg_wdata[2:1] == 2'd1) ? ST_RD : ST_WR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                app_en       = app_wdf_rdy;
                w_accept     = app_wdf_rdy && app_rdy;
                app_wdf_wren = w_accept;
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_accept && w_last) begin
                    w_state_nxt = (r_mode == 2'd2) ? ST_RD : ST_IDLE;
                end else begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_RD: begin
                app_cmd  = 3'd1;
                app_en   = (r_outstanding < OW'(MAX_OUTSTANDING));
                w_accept = app_en && app_rdy;
                if (w_stop || (w_accept && w_last)) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_DRAIN: begin
                if (r_outstanding == {OW{1'b0}}) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Software-visible configuration registers; mode/xor frozen during a run.
    always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_ui_aresetn) begin
        if (!c0_ddr4_ui_aresetn) begin
            r_mode    <= 2'd0;
            r_xor     <= 1'b0;
            r_count   <= 32'd0;
            r_base    <= '0;
            r_pattern <= 32'd0;
        end else begin
            if (w_ctrl_we && (r_state == ST_IDLE)) begin
                r_mode <= reg_wdata[2:1];
                r_xor  <= reg_wdata[3];
            end
            if (reg_we && (reg_addr == A_COUNT)) begin
                r_count <= reg_wdata;
            end
            if (reg_we && (reg_addr == A_BASE)) begin
                r_base <= reg_wdata[APP_ADDR_W-1:0];
            end
            if (reg_we && (reg_addr == A_PAT)) begin
                r_pattern <= reg_wdata;
            end
        end
    end

    // Issue index and command address; the address wraps at APP_ADDR_W bits.
    always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_ui_aresetn) begin
        if (!c0_ddr4_ui_aresetn) begin
            r_n    <= 32'd0;
            r_addr <= '0;
        end else if (w_start_ok) begin
            r_n    <= 32'd0;
            r_addr <= r_base;
        end else if (w_accept) begin
            if ((r_state == ST_WR) && w_last && (r_mode == 2'd2)) begin
                r_n    <= 32'd0;
                r_addr <= r_base;
            end else begin
                r_n    <= r_n + 32'd1;
                r_addr <= r_addr + APP_ADDR_W'(ADDR_STEP);
            end
        end else begin
            r_n    <= r_n;
            r_addr <= r_addr;
        end
    end

    // Reads in flight; simultaneous issue and return cancel out.
    always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_ui_aresetn) begin
        if (!c0_ddr4_ui_aresetn) begin
            r_outstanding <= {OW{1'b0}};
        end else if (w_rd_acc && !w_rd_ret) begin
            r_outstanding <= r_outstanding + 7'd1;
        end else if (!w_rd_acc && w_rd_ret) begin
            r_outstanding <= r_outstanding - 7'd1;
        end else begin
            r_outstanding <= r_outstanding;
        end
    end

    // Read data capture; returns arriving while idle are dropped unchecked.
    always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_ui_aresetn) begin
        if (!c0_ddr4_ui_aresetn) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_vld  <= app_rd_data_valid && (r_state != ST_IDLE);
            r_rd_data <= app_rd_data;
        end
    end

    // Check index, first-error capture and error flag.
    always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_ui_aresetn) begin
        if (!c0_ddr4_ui_aresetn) begin
            r_m             <= 32'd0;
            r_first_err_idx <= 32'd0;
            r_err_seen      <= 1'b0;
        end else if (w_start_ok) begin
            r_m             <= 32'd0;
            r_first_err_idx <= 32'd0;
            r_err_seen      <= 1'b0;
        end else if (r_rd_vld) begin
            r_m <= r_m + 32'd1;
            if (w_mis && !r_err_seen) begin
                r_first_err_idx <= r_m;
                r_err_seen      <= 1'b1;
            end
        end else begin
            r_m <= r_m;
        end
    end

    // Saturating mismatch counter; any register write to it clears it.
    always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_ui_aresetn) begin
        if (!c0_ddr4_ui_aresetn) begin
            r_err_cnt <= 32'd0;
        end else if (w_start_ok || (reg_we && (reg_addr == A_ERR))) begin
            r_err_cnt <= 32'd0;
        end else if (w_mis && (r_err_cnt != 32'hFFFF_FFFF)) begin
            r_err_cnt <= r_err_cnt + 32'd1;
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    // Saturating count of non-idle cycles in the current run.
    always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_ui_aresetn) begin
        if (!c0_ddr4_ui_aresetn) begin
            r_busy_cycles <= 32'd0;
        end else if (w_start_ok) begin
            r_busy_cycles <= 32'd0;
        end else if ((r_state != ST_IDLE) && (r_busy_cycles != 32'hFFFF_FFFF)) begin
            r_busy_cycles <= r_busy_cycles + 32'd1;
        end else begin
            r_busy_cycles <= r_busy_cycles;
        end
    end

    // Done flag and start-rejected sticky bit.
    always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_ui_aresetn) begin
        if (!c0_ddr4_ui_aresetn) begin
            r_done      <= 1'b0;
            r_start_rej <= 1'b0;
        end else begin
            r_done <= (r_state == ST_IDLE);
            if (w_start_ok) begin
                r_start_rej <= 1'b0;
            end else if (w_start_rej) begin
                r_start_rej <= 1'b1;
            end else begin
                r_start_rej <= r_start_rej;
            end
        end
    end

    // Register read mux.
    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            A_CTRL:   reg_rdata = {28'd0, r_xor, r_mode, 1'b0};
            A_STATUS: reg_rdata = {c0_init_calib_complete, app_rdy, 19'd0, r_state,
                                   4'd0, r_start_rej, r_err_seen, !r_done, r_done};
            A_COUNT:  reg_rdata = r_count;
            A_BASE:   reg_rdata = 32'(r_base);
            A_PAT:    reg_rdata = r_pattern;
            A_ERR:    reg_rdata = r_err_cnt;
            A_FIRST:  reg_rdata = r_first_err_idx;
            A_BUSY:   reg_rdata = r_busy_cycles;
            default:  reg_rdata = 32'd0;
        endcase
    end

endmodule
